conv3x3_window_gen: RTL

Upstream feeder for the 3x3 single-channel convolution stage. It accepts a raster-order pixel stream, one pixel per cycle at most, for a fixed IMG_W x IMG_H frame. It keeps two line buffers plus a 3x3 shift window and emits the nine window taps p00..p22 with a one-cycle win_valid strobe. It uses valid (unpadded) convolution, so each frame yields (IMG_W-2)*(IMG_H-2) windows. The outputs connect directly to the conv stage's in_valid/p00..p22 inputs.

---
 rtl/conv3x3_window_gen_pkg.sv | 17 +
 rtl/conv3x3_line_buf.sv | 27 ++
 rtl/conv3x3_window_gen.sv | 120 ++++++++++++
 3 files changed

// File: rtl/conv3x3_window_gen_pkg.sv
// Shared constants for the 3x3 convolution front end: default pixel width, frame
// geometry and the counter-width helper used by the window generator and conv stage.
package conv3x3_window_gen_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int IMG_W_DEF  = 28;
    localparam int IMG_H_DEF  = 28;

    // Width of a counter spanning 0..n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int COL_W_DEF = cnt_w(IMG_W_DEF);
    localparam int ROW_W_DEF = cnt_w(IMG_H_DEF);

endpackage

// File: rtl/conv3x3_line_buf.sv
// One raster line of pixels indexed by column; asynchronous read, synchronous write,
// so a read and write to the same column in one cycle returns the old contents.
module conv3x3_line_buf
    import conv3x3_window_gen_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = IMG_W_DEF,
    parameter int ADDR_W = cnt_w(DEPTH)
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic        [ADDR_W-1:0] addr,
    input  logic signed [DATA_W-1:0] wr_data,
    output logic signed [DATA_W-1:0] rd_data
);

    logic signed [DATA_W-1:0] mem [DEPTH];

    assign rd_data = mem[addr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/conv3x3_window_gen.sv
// Raster-stream to 3x3 window converter: two line buffers plus a shifting tap array,
// flagging only windows that lie fully inside the current frame.
module conv3x3_window_gen
    import conv3x3_window_gen_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic signed [DATA_W-1:0]       pix_in,
    input  logic                           pix_valid,
    output logic signed [DATA_W-1:0]       p00,
    output logic signed [DATA_W-1:0]       p01,
    output logic signed [DATA_W-1:0]       p02,
    output logic signed [DATA_W-1:0]       p10,
    output logic signed [DATA_W-1:0]       p11,
    output logic signed [DATA_W-1:0]       p12,
    output logic signed [DATA_W-1:0]       p20,
    output logic signed [DATA_W-1:0]       p21,
    output logic signed [DATA_W-1:0]       p22,
    output logic                           win_valid,
    output logic                           frame_done,
    output logic [cnt_w(IMG_W)-1:0]        col_cnt,
    output logic [cnt_w(IMG_H)-1:0]        row_cnt
);

    localparam int COL_W = cnt_w(IMG_W);
    localparam int ROW_W = cnt_w(IMG_H);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

    logic signed [DATA_W-1:0] win [3][3];
    logic signed [DATA_W-1:0] lb1_rd;
    logic signed [DATA_W-1:0] lb2_rd;
    logic                     acc;
    logic                     col_last;
    logic                     row_last;
    logic                     win_ok;

    // A pixel presented during reset is dropped, so it must not touch the line buffers.
    assign acc      = pix_valid & ~rst;
    assign col_last = (col_cnt == COL_LAST);
    assign row_last = (row_cnt == ROW_LAST);
    assign win_ok   = (row_cnt >= ROW_TWO) && (col_cnt >= COL_TWO);

    // lb1 holds row r-1; its old word cascades into lb2 (row r-2) in the same cycle.
    conv3x3_line_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (IMG_W),
        .ADDR_W (COL_W)
    ) u_lb1 (
        .clk     (clk),
        .wr_en   (acc),
        .addr    (col_cnt),
        .wr_data (pix_in),
        .rd_data (lb1_rd)
    );

    conv3x3_line_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (IMG_W),
        .ADDR_W (COL_W)
    ) u_lb2 (
        .clk     (clk),
        .wr_en   (acc),
        .addr    (col_cnt),
        .wr_data (lb1_rd),
        .rd_data (lb2_rd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            col_cnt    <= '0;
            row_cnt    <= '0;
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    win[i][j] <= '0;
                end
            end
        end else begin
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (pix_valid) begin
                for (int i = 0; i < 3; i++) begin
                    win[i][0] <= win[i][1];
                    win[i][1] <= win[i][2];
                end
                win[0][2]  <= lb2_rd;
                win[1][2]  <= lb1_rd;
                win[2][2]  <= pix_in;
                // Columns 0/1 still carry the previous row's tail, hence the c>=2 gate.
                win_valid  <= win_ok;
                frame_done <= col_last && row_last;
                if (col_last) begin
                    col_cnt <= '0;
                    row_cnt <= row_last ? '0 : row_cnt + ROW_W'(1);
                end else begin
                    col_cnt <= col_cnt + COL_W'(1);
                end
            end
        end
    end

    assign p00 = win[0][0];
    assign p01 = win[0][1];
    assign p02 = win[0][2];
    assign p10 = win[1][0];
    assign p11 = win[1][1];
    assign p12 = win[1][2];
    assign p20 = win[2][0];
    assign p21 = win[2][1];
    assign p22 = win[2][2];

endmodule
